// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the ProtoCore 8-bit datapath.
// Owns PC, IR and the Z/C flags, and drives register-file, ALU and data-RAM controls.
module control_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [7:0]      ram_addr,
  output logic            ram_we,
  output logic [7:0]      ram_wdata,
  input  logic [7:0]      read_a,
  input  logic [7:0]      read_b,
  input  logic            alu_zero,
  input  logic            alu_carry,
  output logic [2:0]      alu_opcode,
  output logic [3:0]      ra_addr,
  output logic [3:0]      rb_addr,
  output logic [3:0]      write_addr,
  output logic            write_en,
  output logic            write_alu,
  output logic            is_load,
  output logic            imm_flag,
  output logic [7:0]      imm_data,
  output logic            halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            z_q, z_d, c_q, c_d;
  logic [7:0]      maddr_q, maddr_d;

  logic [3:0]      op;
  logic [PC_W-1:0] jmp_pc;
  logic            in_exec, in_mem, is_alu;

  assign op      = ir_q[15:12];
  // Size cast truncates or zero-extends imm8 to the PC width.
  assign jmp_pc  = PC_W'(ir_q[7:0]);
  assign in_exec = (state_q == S_EXEC);
  assign in_mem  = (state_q == S_MEM);
  assign is_alu  = ~op[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
      maddr_q <= maddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    c_d     = c_q;
    maddr_d = maddr_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = imem_data;
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_alu) begin
          z_d = alu_zero;
          c_d = alu_carry;
        end else begin
          case (op)
            OP_LD:  begin
              state_d = S_MEM;
              maddr_d = read_a;
            end
            OP_JMP: pc_d = jmp_pc;
            OP_JZ:  if (z_q) pc_d = jmp_pc;
            OP_JC:  if (c_q) pc_d = jmp_pc;
            OP_HLT: state_d = S_HALT;
            default: ;
          endcase
        end
      end
      S_MEM:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  assign imem_addr  = pc_q;
  assign ra_addr    = ir_q[7:4];
  assign rb_addr    = ir_q[3:0];
  assign write_addr = ir_q[11:8];

  assign alu_opcode = (in_exec && is_alu) ? op[2:0] : 3'd0;
  assign write_alu  = in_exec && is_alu;
  assign imm_flag   = in_exec && (op == OP_LDI);
  assign is_load    = in_mem;
  assign write_en   = write_alu | imm_flag | is_load;
  assign imm_data   = imm_flag ? ir_q[7:0] : 8'd0;

  assign ram_we     = in_exec && (op == OP_ST);
  assign ram_wdata  = ram_we ? read_b : 8'd0;
  // Address is live from the register file in EXEC and held from the capture in MEM.
  assign ram_addr   = (in_exec && (op == OP_LD || op == OP_ST)) ? read_a :
                      in_mem ? maddr_q : 8'd0;

  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: behavioural ROM, register file, ALU and data RAM around the sequencer,
// a decode/execute vector table and hand-written multi-cycle sequences.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  ram_addr, ram_wdata, read_a, read_b, imm_data;
  logic        ram_we, alu_zero, alu_carry;
  logic [2:0]  alu_opcode;
  logic [3:0]  ra_addr, rb_addr, write_addr;
  logic        write_en, write_alu, is_load, imm_flag, halted;

  always #5 clk = ~clk;

  control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .read_a(read_a), .read_b(read_b),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_opcode(alu_opcode),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .write_addr(write_addr),
    .write_en(write_en), .write_alu(write_alu), .is_load(is_load), .imm_flag(imm_flag),
    .imm_data(imm_data), .halted(halted)
  );

  // Datapath and memories
  logic [15:0] rom [256];
  logic [7:0]  ram [256];
  logic [7:0]  rf  [16];
  logic [7:0]  alu_r;
  logic        alu_c;

  assign read_a = rf[ra_addr];
  assign read_b = rf[rb_addr];

  always_comb begin
    alu_r = 8'd0;
    alu_c = 1'b0;
    case (alu_opcode)
      3'd0: {alu_c, alu_r} = {1'b0, read_a} + {1'b0, read_b};
      3'd1: begin alu_r = read_a - read_b; alu_c = (read_a < read_b); end
      3'd2: alu_r = read_a & read_b;
      3'd3: alu_r = read_a | read_b;
      3'd4: alu_r = read_a ^ read_b;
      3'd5: alu_r = ~read_a;
      3'd6: {alu_c, alu_r} = {read_a, 1'b0};
      default: begin alu_r = read_a >> 1; alu_c = read_a[0]; end
    endcase
  end
  assign alu_zero  = (alu_r == 8'd0);
  assign alu_carry = alu_c;

  always @(posedge clk) begin
    imem_data <= rom[imem_addr];
    if (ram_we) ram[ram_addr] <= ram_wdata;
    if (write_en) rf[write_addr] <= write_alu ? alu_r : is_load ? ram[ram_addr] : imm_data;
  end

  // Checking
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic start();
    run = 1'b1;
    step(1);
  endtask

  function automatic logic [4:0] ctl();
    return {write_en, write_alu, is_load, imm_flag, ram_we};
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({ram_addr, ram_we, ram_wdata, alu_opcode, ra_addr, rb_addr, write_addr,
                write_en, write_alu, is_load, imm_flag, imm_data, halted});
  endfunction

  // kind: 0 none, 1 register rf[dst]==val, 2 store to RAM[dst] of val
  typedef struct {
    logic [15:0] instr;
    logic [4:0]  ctl;
    logic [2:0]  aop;
    logic [1:0]  kind;
    logic [7:0]  dst;
    logic [7:0]  val;
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{16'h8105, 5'b10010, 3'd0, 2'd1, 8'd1,  8'h05}; // LDI r1,05
    vt[1]  = '{16'h8203, 5'b10010, 3'd0, 2'd1, 8'd2,  8'h03}; // LDI r2,03
    vt[2]  = '{16'h0312, 5'b11000, 3'd0, 2'd1, 8'd3,  8'h08}; // ADD
    vt[3]  = '{16'h1412, 5'b11000, 3'd1, 2'd1, 8'd4,  8'h02}; // SUB
    vt[4]  = '{16'h2512, 5'b11000, 3'd2, 2'd1, 8'd5,  8'h01}; // AND
    vt[5]  = '{16'h3612, 5'b11000, 3'd3, 2'd1, 8'd6,  8'h07}; // OR
    vt[6]  = '{16'h4712, 5'b11000, 3'd4, 2'd1, 8'd7,  8'h06}; // XOR
    vt[7]  = '{16'h5810, 5'b11000, 3'd5, 2'd1, 8'd8,  8'hFA}; // NOT
    vt[8]  = '{16'h6910, 5'b11000, 3'd6, 2'd1, 8'd9,  8'h0A}; // SHL
    vt[9]  = '{16'h7A10, 5'b11000, 3'd7, 2'd1, 8'd10, 8'h02}; // SHR
    vt[10] = '{16'hA012, 5'b00001, 3'd0, 2'd2, 8'h05, 8'h03}; // ST [r1]<=r2
    vt[11] = '{16'hE000, 5'b00000, 3'd0, 2'd0, 8'd0,  8'h00}; // NOP

    // Reset state
    run = 1'b0;
    rst = 1'b1;
    clear_rom();
    step(2);
    chk("reset_outs", all_outs(), 64'd0);
    chk("reset_pc", 64'(imem_addr), 64'd0);
    rst = 1'b0;
    step(3);
    chk("idle_pc", 64'(imem_addr), 64'd0);
    chk("idle_ctl", 64'(ctl()), 64'd0);

    // Vector table: 3 cycles per instruction
    clear_rom();
    for (int i = 0; i < 12; i++) rom[i] = vt[i].instr;
    do_reset();
    start();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_pc", i), 64'(imem_addr), 64'(i));
      chk($sformatf("v%0d_fetch_ctl", i), 64'(ctl()), 64'd0);
      step(2);
      chk($sformatf("v%0d_exec_ctl", i), 64'(ctl()), 64'(vt[i].ctl));
      if (vt[i].ctl[3]) chk($sformatf("v%0d_aop", i), 64'(alu_opcode), 64'(vt[i].aop));
      if (vt[i].ctl[1]) chk($sformatf("v%0d_imm", i), 64'(imm_data), 64'(vt[i].val));
      if (vt[i].ctl[0]) begin
        chk($sformatf("v%0d_raddr", i), 64'(ram_addr), 64'(vt[i].dst));
        chk($sformatf("v%0d_wdata", i), 64'(ram_wdata), 64'(vt[i].val));
      end
      step(1);
      if (vt[i].kind == 2'd1) chk($sformatf("v%0d_rd", i), 64'(rf[vt[i].dst[3:0]]), 64'(vt[i].val));
      if (vt[i].kind == 2'd2) chk($sformatf("v%0d_ram", i), 64'(ram[vt[i].dst]), 64'(vt[i].val));
    end

    // Reset in the EXEC cycle of a store
    clear_rom();
    rom[0] = 16'h8150; rom[1] = 16'h8211; rom[2] = 16'hA012;
    rom[3] = 16'h8277; rom[4] = 16'hA012;
    do_reset();
    start();
    step(12);
    step(2);
    chk("st_we_before_rst", 64'(ram_we), 64'd1);
    #2;
    rst = 1'b1;
    run = 1'b0;
    #1;
    chk("st_we_rst", 64'(ram_we), 64'd0);
    chk("st_rst_outs", all_outs(), 64'd0);
    step(1);
    rst = 1'b0;
    step(1);
    chk("st_rst_pc", 64'(imem_addr), 64'd0);
    chk("st_rst_halted", 64'(halted), 64'd0);
    chk("st_rst_ram", 64'(ram[8'h50]), 64'h11);

    // Overflowing ADD sets Z and C; JC taken; HLT absorbs
    clear_rom();
    rom[0] = 16'h81FF; rom[1] = 16'h8201; rom[2] = 16'h0312; rom[3] = 16'hD020;
    do_reset();
    start();
    step(9);
    chk("c_add_r3", 64'(rf[3]), 64'd0);
    step(3);
    chk("c_jc_pc", 64'(imem_addr), 64'h20);
    step(3);
    chk("halt_flag", 64'(halted), 64'd1);
    run = 1'b0;
    step(2);
    run = 1'b1;
    step(2);
    chk("halt_stay", 64'(halted), 64'd1);
    chk("halt_pc", 64'(imem_addr), 64'h21);
    chk("halt_ctl", 64'(ctl()), 64'd0);

    // JZ taken across LDI, then not taken after nonzero ADD
    clear_rom();
    rom[0]     = 16'h1111; rom[1]     = 16'h8400; rom[2]     = 16'hC010;
    rom[8'h10] = 16'h8501; rom[8'h11] = 16'h0655; rom[8'h12] = 16'hC030;
    do_reset();
    start();
    step(9);
    chk("jz_taken_pc", 64'(imem_addr), 64'h10);
    step(9);
    chk("jz_nt_pc", 64'(imem_addr), 64'h13);
    chk("jz_r6", 64'(rf[6]), 64'h02);

    // Store then load: LD takes 4 cycles, is_load only in MEM
    clear_rom();
    rom[0] = 16'h8140; rom[1] = 16'h82AA; rom[2] = 16'hA012; rom[3] = 16'h9510;
    do_reset();
    start();
    step(9);
    chk("ld_fetch_pc", 64'(imem_addr), 64'd3);
    step(2);
    chk("ld_exec_ctl", 64'(ctl()), 64'd0);
    chk("ld_exec_addr", 64'(ram_addr), 64'h40);
    step(1);
    chk("ld_mem_ctl", 64'(ctl()), 64'b10100);
    chk("ld_mem_addr", 64'(ram_addr), 64'h40);
    step(1);
    chk("ld_next_pc", 64'(imem_addr), 64'd4);
    chk("ld_next_ctl", 64'(ctl()), 64'd0);
    chk("ld_r5", 64'(rf[5]), 64'hAA);
    chk("st_ram40", 64'(ram[8'h40]), 64'hAA);

    // JMP to the last address, NOP there, PC wraps to 0
    clear_rom();
    rom[0] = 16'hB0FF; rom[8'hFF] = 16'hE000;
    do_reset();
    start();
    step(3);
    chk("jmp_ff_pc", 64'(imem_addr), 64'hFF);
    step(3);
    chk("wrap_pc", 64'(imem_addr), 64'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
